// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared Wishbone bus widths, request/response bundles and the
//                arbiter state encoding for the on-chip memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Master-to-slave half of a classic Wishbone link
    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_req_t;

    // Slave-to-master half of a classic Wishbone link
    typedef struct packed {
        logic                ack;
        logic                err;
        logic [WB_DAT_W-1:0] dat;
    } wb_rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle around the two-master / one-memory arbiter.
//                "slave" is the arbiter's view, "master" the environment's.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_bus_pkg::*;

    // Master 0: instruction fetch
    logic                m0_cyc_i;
    logic                m0_stb_i;
    logic                m0_we_i;
    logic [WB_SEL_W-1:0] m0_sel_i;
    logic [WB_ADR_W-1:0] m0_adr_i;
    logic [WB_DAT_W-1:0] m0_dat_i;
    logic                m0_ack_o;
    logic                m0_err_o;
    logic [WB_DAT_W-1:0] m0_dat_o;

    // Master 1: load/store
    logic                m1_cyc_i;
    logic                m1_stb_i;
    logic                m1_we_i;
    logic [WB_SEL_W-1:0] m1_sel_i;
    logic [WB_ADR_W-1:0] m1_adr_i;
    logic [WB_DAT_W-1:0] m1_dat_i;
    logic                m1_ack_o;
    logic                m1_err_o;
    logic [WB_DAT_W-1:0] m1_dat_o;

    // Memory side
    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [WB_SEL_W-1:0] s_sel_o;
    logic [WB_ADR_W-1:0] s_adr_o;
    logic [WB_DAT_W-1:0] s_dat_o;
    logic                s_ack_i;
    logic [WB_DAT_W-1:0] s_dat_i;

    logic [1:0]          grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  grant_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : wb_watchdog
//  Description : Counts cycles a strobe waits for ack; flags timeout on the
//                TIMEOUT-th waiting cycle. Saturates, never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic stb,
    input  wire logic ack,
    output logic      timeout
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wait;

    assign w_wait  = en & stb & ~ack;
    assign timeout = w_wait & (r_cnt == c_LAST);

    // Count waiting cycles; any ack, idle strobe or loss of ownership clears
    always_ff @(posedge clk) begin
        if (rst || !w_wait) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin two-master Wishbone arbiter for on-chip memory.
//                Grant is held for the whole cyc; a watchdog errors stalled
//                strobes and parks the owner in DRAIN until it drops cyc.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic     sys_clk,
    input  wire logic     sys_rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       w_last_grant_nxt;

    wb_req_t    w_req0;
    wb_req_t    w_req1;
    wb_req_t    w_req_mux;
    wb_rsp_t    w_rsp_own;
    wb_rsp_t    w_rsp0;
    wb_rsp_t    w_rsp1;
    logic       w_s_cyc;
    logic       w_s_stb;
    logic [1:0] w_grant;

    logic       w_wd_en;
    logic       w_wd_stb;
    logic       w_timeout;

    assign w_req0 = '{cyc: bus.m0_cyc_i, stb: bus.m0_stb_i, we: bus.m0_we_i,
                      sel: bus.m0_sel_i, adr: bus.m0_adr_i, dat: bus.m0_dat_i};
    assign w_req1 = '{cyc: bus.m1_cyc_i, stb: bus.m1_stb_i, we: bus.m1_we_i,
                      sel: bus.m1_sel_i, adr: bus.m1_adr_i, dat: bus.m1_dat_i};

    // Watchdog inputs come straight from state so they never loop through the FSM logic
    assign w_wd_en  = (r_state == OWN0) || (r_state == OWN1);
    assign w_wd_stb = (r_state == OWN1) ? bus.m1_stb_i : bus.m0_stb_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .en      (w_wd_en),
        .stb     (w_wd_stb),
        .ack     (bus.s_ack_i),
        .timeout (w_timeout)
    );

    // State and round-robin history; reset makes master 0 win the first tie
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state, bus mux and response routing
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_req_mux        = w_req0;
        w_rsp_own        = '0;
        w_rsp0           = '0;
        w_rsp1           = '0;
        w_s_cyc          = 1'b0;
        w_s_stb          = 1'b0;
        w_grant          = 2'b00;

        case (r_state)
            IDLE: begin
                if (w_req0.cyc && (!w_req1.cyc || r_last_grant)) begin
                    w_state_nxt      = OWN0;
                    w_last_grant_nxt = 1'b0;
                end else if (w_req1.cyc) begin
                    w_state_nxt      = OWN1;
                    w_last_grant_nxt = 1'b1;
                end
            end

            OWN0, OWN1: begin
                w_req_mux     = (r_state == OWN1) ? w_req1 : w_req0;
                w_grant       = (r_state == OWN1) ? 2'b10 : 2'b01;
                // Dropping cyc closes the memory cycle in the same clock
                w_s_cyc       = w_req_mux.cyc;
                w_s_stb       = w_req_mux.cyc & w_req_mux.stb;
                w_rsp_own.ack = bus.s_ack_i & w_req_mux.stb;
                w_rsp_own.err = w_timeout;
                w_rsp_own.dat = bus.s_dat_i;
                if (r_state == OWN1) begin
                    w_rsp1 = w_rsp_own;
                end else begin
                    w_rsp0 = w_rsp_own;
                end
                // A cyc drop wins over timeout: err still pulses but go straight to IDLE
                if (!w_req_mux.cyc) begin
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                w_req_mux = r_last_grant ? w_req1 : w_req0;
                w_grant   = r_last_grant ? 2'b10 : 2'b01;
                if (!w_req_mux.cyc) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.s_cyc_o  = w_s_cyc;
    assign bus.s_stb_o  = w_s_stb;
    assign bus.s_we_o   = w_req_mux.we;
    assign bus.s_sel_o  = w_req_mux.sel;
    assign bus.s_adr_o  = w_req_mux.adr;
    assign bus.s_dat_o  = w_req_mux.dat;

    assign bus.m0_ack_o = w_rsp0.ack;
    assign bus.m0_err_o = w_rsp0.err;
    assign bus.m0_dat_o = w_rsp0.dat;
    assign bus.m1_ack_o = w_rsp1.ack;
    assign bus.m1_err_o = w_rsp1.err;
    assign bus.m1_dat_o = w_rsp1.dat;

    assign bus.grant_o  = w_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: cycle vectors with a
//                forced slave ack, then transfer sequences against a small
//                registered-ack memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          TIMEOUT = 16;
    localparam logic [29:0] c_A0    = 30'h111;
    localparam logic [29:0] c_A1    = 30'h222;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 sys_clk = ~sys_clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Memory model: registered ack one cycle after a strobe, byte-lane writes
    logic        use_tbl = 1'b1;
    logic        tbl_ack = 1'b0;
    logic        mem_ack;
    logic [31:0] mem_dat;
    logic [31:0] mem [0:15];

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mem_ack <= 1'b0;
            mem_dat <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hDEADBEEF;
        end else if (bus.s_cyc_o && bus.s_stb_o && !mem_ack) begin
            mem_ack <= 1'b1;
            mem_dat <= mem[bus.s_adr_o[3:0]];
            if (bus.s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.s_sel_o[b]) mem[bus.s_adr_o[3:0]][8*b +: 8] <= bus.s_dat_o[8*b +: 8];
            end
        end else begin
            mem_ack <= 1'b0;
        end
    end

    assign bus.s_ack_i = use_tbl ? tbl_ack : mem_ack;
    assign bus.s_dat_i = mem_dat;

    typedef struct {
        logic        c0, s0, c1, s1, ack;
        logic [1:0]  grant;
        logic        scyc, a0, a1;
        logic [29:0] adr;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g,
                                input logic [2:0] o, input bit sel_m1);
        vec_t v;
        {v.c0, v.s0, v.c1, v.s1, v.ack} = in;
        v.grant = g;
        {v.scyc, v.a0, v.a1} = o;
        v.adr = sel_m1 ? c_A1 : c_A0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_masters();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_sel_i = 0;
        bus.m0_adr_i = 0; bus.m0_dat_i = 0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_sel_i = 0;
        bus.m1_adr_i = 0; bus.m1_dat_i = 0;
    endtask

    task automatic wait_ack(input bit m);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge sys_clk);
            got = m ? bus.m1_ack_o : bus.m0_ack_o;
        end
        chk(m ? "ack_seen_m1" : "ack_seen_m0", 64'(got), 64'd1);
    endtask

    task automatic xfer(input bit m, input bit we, input logic [29:0] adr,
                        input logic [3:0] sel, input logic [31:0] wd, output logic [31:0] rd);
        @(posedge sys_clk); #1;
        if (m) begin
            bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = we;
            bus.m1_adr_i = adr; bus.m1_sel_i = sel; bus.m1_dat_i = wd;
        end else begin
            bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = we;
            bus.m0_adr_i = adr; bus.m0_sel_i = sel; bus.m0_dat_i = wd;
        end
        wait_ack(m);
        rd = m ? bus.m1_dat_o : bus.m0_dat_o;
        @(posedge sys_clk); #1;
        if (m) begin bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; end
        else   begin bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          err_cnt;
        int          err_at;
        logic        drain_bad;
        logic        seen;

        // Inputs c0 s0 c1 s1 ack | grant | s_cyc m0_ack m1_ack | s_adr from m1?
        tbl[0]  = mk(5'b11110, 2'b00, 3'b000, 0);
        tbl[1]  = mk(5'b11111, 2'b01, 3'b110, 0);
        tbl[2]  = mk(5'b00110, 2'b01, 3'b000, 0);
        tbl[3]  = mk(5'b00110, 2'b00, 3'b000, 0);
        tbl[4]  = mk(5'b00111, 2'b10, 3'b101, 1);
        tbl[5]  = mk(5'b00101, 2'b10, 3'b100, 1);
        tbl[6]  = mk(5'b11110, 2'b10, 3'b100, 1);
        tbl[7]  = mk(5'b11000, 2'b10, 3'b000, 1);
        tbl[8]  = mk(5'b11110, 2'b00, 3'b000, 0);
        tbl[9]  = mk(5'b11111, 2'b01, 3'b110, 0);
        tbl[10] = mk(5'b00110, 2'b01, 3'b000, 0);
        tbl[11] = mk(5'b11110, 2'b00, 3'b000, 0);
        tbl[12] = mk(5'b11111, 2'b10, 3'b101, 1);
        tbl[13] = mk(5'b00000, 2'b10, 3'b000, 1);
        tbl[14] = mk(5'b00000, 2'b00, 3'b000, 0);

        clear_masters();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_state", {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o,
                            bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 64'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Cycle vectors with the slave ack driven from the table
        bus.m0_adr_i = c_A0;
        bus.m1_adr_i = c_A1;
        for (int i = 0; i < 15; i++) begin
            @(posedge sys_clk); #1;
            bus.m0_cyc_i = tbl[i].c0; bus.m0_stb_i = tbl[i].s0;
            bus.m1_cyc_i = tbl[i].c1; bus.m1_stb_i = tbl[i].s1;
            tbl_ack      = tbl[i].ack;
            @(negedge sys_clk);
            chk($sformatf("vec%0d", i),
                {bus.grant_o, bus.s_cyc_o, bus.m0_ack_o, bus.m1_ack_o,
                 bus.m0_err_o, bus.m1_err_o, bus.s_adr_o},
                {tbl[i].grant, tbl[i].scyc, tbl[i].a0, tbl[i].a1, 2'b00, tbl[i].adr});
        end
        clear_masters();
        tbl_ack = 1'b0;
        use_tbl = 1'b0;

        // Single read with latency: s_cyc in k+1, ack and data in k+2
        @(posedge sys_clk); #1;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_sel_i = 4'hF; bus.m0_adr_i = 30'h0;
        @(negedge sys_clk);
        chk("rd_k_scyc", 64'(bus.s_cyc_o), 64'd0);
        @(negedge sys_clk);
        chk("rd_k1", {bus.grant_o, bus.s_cyc_o, bus.m0_ack_o}, {2'b01, 1'b1, 1'b0});
        @(negedge sys_clk);
        chk("rd_k2_ack", {bus.grant_o, bus.m0_ack_o, bus.m1_ack_o}, {2'b01, 1'b1, 1'b0});
        chk("rd_k2_data", bus.m0_dat_o, 64'hDEADBEEF);
        chk("rd_k2_m1_dat", bus.m1_dat_o, 64'h0);
        @(posedge sys_clk); #1;
        clear_masters();

        // Partial write then full read-back by master 1
        xfer(1'b1, 1'b1, 30'd5, 4'b0011, 32'h12345678, rd);
        xfer(1'b1, 1'b0, 30'd5, 4'hF, 32'h0, rd);
        chk("wr_rd_data", rd, 64'h00005678);

        // Owner keeps the bus across three strobes while master 1 waits
        @(posedge sys_clk); #1;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 30'd0; bus.m0_sel_i = 4'hF;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 30'd5; bus.m1_sel_i = 4'hF;
        for (int p = 0; p < 3; p++) begin
            wait_ack(1'b0);
            chk($sformatf("held_grant%0d", p), {bus.grant_o, bus.m1_ack_o}, {2'b01, 1'b0});
            @(posedge sys_clk); #1;
            bus.m0_stb_i = 0;
            if (p < 2) begin
                @(posedge sys_clk); #1;
                bus.m0_stb_i = 1;
            end
        end
        @(posedge sys_clk); #1;
        bus.m0_cyc_i = 0;
        @(negedge sys_clk);
        chk("held_drop", {bus.grant_o, bus.s_cyc_o}, {2'b01, 1'b0});
        @(negedge sys_clk);
        chk("held_gap", {bus.grant_o, bus.s_cyc_o}, {2'b00, 1'b0});
        @(negedge sys_clk);
        chk("held_handover", bus.grant_o, 64'(2'b10));
        wait_ack(1'b1);
        chk("held_m1_data", bus.m1_dat_o, 64'h00005678);
        @(posedge sys_clk); #1;
        clear_masters();

        // Watchdog: err on the TIMEOUT-th cycle of s_stb without ack, then DRAIN
        use_tbl = 1'b1;
        tbl_ack = 1'b0;
        @(posedge sys_clk); #1;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 30'd7;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge sys_clk);
            seen = bus.s_stb_o;
        end
        chk("wd_stb_rise", 64'(seen), 64'd1);
        err_cnt   = 0;
        err_at    = -1;
        drain_bad = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) @(negedge sys_clk);
            if (bus.m1_err_o) begin
                err_cnt++;
                if (err_at < 0) err_at = n;
            end else if (err_at >= 0 &&
                         (bus.s_cyc_o || bus.s_stb_o || bus.m1_ack_o || bus.grant_o != 2'b10)) begin
                drain_bad = 1'b1;
            end
        end
        chk("wd_err_count", 64'(err_cnt), 64'd1);
        chk("wd_err_cycle", 64'(err_at), 64'(TIMEOUT - 1));
        chk("wd_drain_quiet", 64'(drain_bad), 64'd0);
        @(posedge sys_clk); #1;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        @(negedge sys_clk);
        chk("wd_drain_hold", {bus.grant_o, bus.s_cyc_o}, {2'b10, 1'b0});
        @(negedge sys_clk);
        chk("wd_release", bus.grant_o, 64'(2'b00));

        // Reset while master 1 owns the bus with a pending strobe
        @(posedge sys_clk); #1;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_pre_owner", bus.grant_o, 64'(2'b10));
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_mid_abort", {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o,
                              bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 64'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        @(negedge sys_clk);
        chk("rst_idle", bus.grant_o, 64'(2'b00));
        @(negedge sys_clk);
        chk("rst_tie_m0", bus.grant_o, 64'(2'b01));
        @(posedge sys_clk); #1;
        clear_masters();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
